branch_resolve_unit: RTL and testbench

- EX-side partner of the gshare predictor: tracks every conditional branch the ID stage issues together with its prediction, in a small in-order queue.
- When EX resolves the oldest branch, the block compares the actual outcome against the recorded prediction.
- Raises flush/redirect on a mispredict.
- Drives the predictor's training interface (pred_update, pred_taken, pred_update_idx) one cycle later.
- Keeps hit/miss statistics.

---
 rtl/branch_resolve_unit_pkg.sv | 17 +
 rtl/branch_resolve_unit_queue.sv | 61 ++++++
 rtl/branch_resolve_unit.sv | 113 +++++++++++
 tb/tb_branch_resolve_unit.sv | 220 ++++++++++++++++++++++
 4 files changed

// File: rtl/branch_resolve_unit_pkg.sv
// Shared types for the RV32I branch path.
// Holds the in-flight branch queue entry layout and the sequential PC increment.
// The predictor index width is fixed here so that the queue entry matches the
// default gshare table size.
package rv32i_types;

   localparam int          BHT_IDX_SIZE = 4;
   localparam logic [31:0] PC_INCR      = 32'd4;

   typedef struct packed {
      logic                    pred;
      logic [BHT_IDX_SIZE-1:0] pred_idx;
      logic [31:0]             pc;
      logic [31:0]             pred_addr;
   } br_entry_t;

endpackage

// File: rtl/branch_resolve_unit_queue.sv
// branch_queue: generic circular FIFO with push, pop and whole-queue clear.
// Ports:
//   clk, rst     clock, synchronous active-high reset
//   push, din    write din at the tail (caller guarantees !full)
//   pop          drop the head entry (caller guarantees count != 0)
//   clear        empty the queue; overrides any push/pop in the same cycle
//   head         entry at the read pointer
//   count        number of valid entries (0..DEPTH)
//   full         count == DEPTH, from registered state only
module branch_queue #(
   parameter int WIDTH = 8,
   parameter int DEPTH = 4,
   localparam int PTR_W = $clog2(DEPTH)
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             push,
   input  logic [WIDTH-1:0] din,
   input  logic             pop,
   input  logic             clear,
   output logic [WIDTH-1:0] head,
   output logic [PTR_W:0]   count,
   output logic             full
);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [PTR_W-1:0] wr_ptr;
   logic [PTR_W-1:0] rd_ptr;

   // Storage carries no reset; validity is tracked by count alone.
   always_ff @(posedge clk) begin
      if (push && !clear) begin
         mem[wr_ptr] <= din;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else if (clear) begin
         // Everything in flight is discarded; realigning rd_ptr to wr_ptr
         // empties the ring without touching storage.
         rd_ptr <= wr_ptr;
         count  <= '0;
      end else begin
         if (push) wr_ptr <= wr_ptr + 1'b1;
         if (pop)  rd_ptr <= rd_ptr + 1'b1;
         case ({push, pop})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
      end
   end

   assign head = mem[rd_ptr];
   assign full = (count == (PTR_W+1)'(DEPTH));

endmodule

// File: rtl/branch_resolve_unit.sv
// branch_resolve_unit: EX-side resolution of predicted conditional branches.
// Queues each branch issued by ID with its prediction, checks the oldest one
// when EX resolves it, raises flush/redirect on a mispredict, trains the
// predictor one cycle later and keeps hit/miss statistics.
// Ports:
//   clk, rst                      clock, synchronous active-high reset
//   id_push, id_pred, id_pred_idx, id_pc, id_pred_addr
//                                 branch issued by ID with its prediction
//   id_full                       queue full, ID must stall branch issue
//   ex_resolve, ex_taken, ex_target
//                                 actual outcome of the oldest branch
//   flush, redirect_pc            same-cycle mispredict squash and fetch PC
//   pred_update, pred_taken, pred_update_idx
//                                 registered predictor training port
//   br_total, br_mispred          resolved / mispredicted branch counters
module branch_resolve_unit
   import rv32i_types::*;
#(
   parameter int IDX_SIZE = 4,
   parameter int DEPTH    = 4
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                id_push,
   input  logic                id_pred,
   input  logic [IDX_SIZE-1:0] id_pred_idx,
   input  logic [31:0]         id_pc,
   input  logic [31:0]         id_pred_addr,
   output logic                id_full,
   input  logic                ex_resolve,
   input  logic                ex_taken,
   input  logic [31:0]         ex_target,
   output logic                flush,
   output logic [31:0]         redirect_pc,
   output logic                pred_update,
   output logic                pred_taken,
   output logic [IDX_SIZE-1:0] pred_update_idx,
   output logic [31:0]         br_total,
   output logic [31:0]         br_mispred
);

   localparam int PTR_W = $clog2(DEPTH);
   localparam int ENT_W = $bits(br_entry_t);

   br_entry_t          push_entry;
   br_entry_t          head;
   logic [ENT_W-1:0]   head_bits;
   logic [PTR_W:0]     count;
   logic               push;
   logic               valid_resolve;
   logic               mispredict;

   assign push_entry = '{pred:      id_pred,
                         pred_idx:  BHT_IDX_SIZE'(id_pred_idx),
                         pc:        id_pc,
                         pred_addr: id_pred_addr};

   // A push during a mispredict is wrong-path and is discarded; a push while
   // full is dropped even if the head pops this cycle.
   assign push = id_push && !id_full && !flush;

   branch_queue #(
      .WIDTH (ENT_W),
      .DEPTH (DEPTH)
   ) u_queue (
      .clk   (clk),
      .rst   (rst),
      .push  (push),
      .din   (push_entry),
      .pop   (valid_resolve),
      .clear (flush),
      .head  (head_bits),
      .count (count),
      .full  (id_full)
   );

   assign head = br_entry_t'(head_bits);

   // Compare against the head entry; a correctly predicted taken branch can
   // still mispredict if the computed target differs from the recorded one.
   assign valid_resolve = ex_resolve && (count != '0);
   assign mispredict    = (ex_taken != head.pred) ||
                          (ex_taken && head.pred && (ex_target != head.pred_addr));
   assign flush         = valid_resolve && mispredict;
   assign redirect_pc   = !flush   ? 32'd0     :
                          ex_taken ? ex_target : head.pc + PC_INCR;

   // Training stage: one cycle after the resolve.
   always_ff @(posedge clk) begin
      if (rst) begin
         pred_update     <= 1'b0;
         pred_taken      <= 1'b0;
         pred_update_idx <= '0;
      end else begin
         pred_update <= valid_resolve;
         if (valid_resolve) begin
            pred_taken      <= ex_taken;
            pred_update_idx <= IDX_SIZE'(head.pred_idx);
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         br_total   <= '0;
         br_mispred <= '0;
      end else begin
         if (valid_resolve) br_total   <= br_total + 32'd1;
         if (flush)         br_mispred <= br_mispred + 32'd1;
      end
   end

endmodule

// File: tb/tb_branch_resolve_unit.sv
module tb_branch_resolve_unit;

   localparam int IDX_SIZE = 4;
   localparam int DEPTH    = 4;

   logic                clk = 1'b0;
   logic                rst = 1'b0;
   logic                id_push = 1'b0;
   logic                id_pred = 1'b0;
   logic [IDX_SIZE-1:0] id_pred_idx = '0;
   logic [31:0]         id_pc = '0;
   logic [31:0]         id_pred_addr = '0;
   logic                id_full;
   logic                ex_resolve = 1'b0;
   logic                ex_taken = 1'b0;
   logic [31:0]         ex_target = '0;
   logic                flush;
   logic [31:0]         redirect_pc;
   logic                pred_update;
   logic                pred_taken;
   logic [IDX_SIZE-1:0] pred_update_idx;
   logic [31:0]         br_total;
   logic [31:0]         br_mispred;

   branch_resolve_unit #(.IDX_SIZE(IDX_SIZE), .DEPTH(DEPTH)) dut (
      .clk             (clk),
      .rst             (rst),
      .id_push         (id_push),
      .id_pred         (id_pred),
      .id_pred_idx     (id_pred_idx),
      .id_pc           (id_pc),
      .id_pred_addr    (id_pred_addr),
      .id_full         (id_full),
      .ex_resolve      (ex_resolve),
      .ex_taken        (ex_taken),
      .ex_target       (ex_target),
      .flush           (flush),
      .redirect_pc     (redirect_pc),
      .pred_update     (pred_update),
      .pred_taken      (pred_taken),
      .pred_update_idx (pred_update_idx),
      .br_total        (br_total),
      .br_mispred      (br_mispred)
   );

   always #5 clk = ~clk;

   // Reference model: in-flight branches as a plain queue, oldest at [0].
   typedef struct packed {
      bit        pred;
      bit [3:0]  idx;
      bit [31:0] pc;
      bit [31:0] addr;
   } ent_t;

   ent_t      q[$];
   int        checks = 0;
   int        errors = 0;
   bit [31:0] e_total = 0;
   bit [31:0] e_mis = 0;
   bit        e_upd = 0;
   bit        e_taken = 0;
   bit [3:0]  e_idx = 0;
   logic        obs_flush;
   logic [31:0] obs_redirect;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic check_regs();
      chk("pred_update", 32'(pred_update), 32'(e_upd));
      chk("pred_taken", 32'(pred_taken), 32'(e_taken));
      chk("pred_update_idx", 32'(pred_update_idx), 32'(e_idx));
      chk("br_total", br_total, e_total);
      chk("br_mispred", br_mispred, e_mis);
      chk("id_full_post", 32'(id_full), 32'(q.size() == DEPTH));
   endtask

   // One clock cycle: drive, check combinational outputs, clock, update model, check registers.
   task automatic cyc(input bit push, input bit pred, input bit [3:0] idx,
                      input bit [31:0] pc, input bit [31:0] addr,
                      input bit res, input bit taken, input bit [31:0] tgt);
      bit        vr, mis, full_b;
      ent_t      h;
      bit [31:0] red;
      id_push = push; id_pred = pred; id_pred_idx = idx; id_pc = pc; id_pred_addr = addr;
      ex_resolve = res; ex_taken = taken; ex_target = tgt;
      #2;
      full_b = (q.size() == DEPTH);
      vr = res && (q.size() != 0);
      h = vr ? q[0] : '0;
      mis = vr && ((taken != h.pred) || (taken && h.pred && tgt != h.addr));
      red = !mis ? 32'd0 : (taken ? tgt : h.pc + 32'd4);
      obs_flush = flush;
      obs_redirect = redirect_pc;
      chk("id_full", 32'(id_full), 32'(full_b));
      chk("flush", 32'(flush), 32'(mis));
      chk("redirect_pc", redirect_pc, red);
      @(posedge clk);
      #1;
      id_push = 1'b0;
      ex_resolve = 1'b0;
      if (vr) begin
         void'(q.pop_front());
         e_total++;
         if (mis) begin
            e_mis++;
            q.delete();
         end
      end
      if (push && !full_b && !mis) q.push_back('{pred, idx, pc, addr});
      e_upd = vr;
      if (vr) begin
         e_taken = taken;
         e_idx = h.idx;
      end
      check_regs();
   endtask

   task automatic do_reset();
      rst = 1'b1;
      id_push = 1'b0;
      ex_resolve = 1'b0;
      @(posedge clk);
      #1;
      q.delete();
      e_total = 0; e_mis = 0; e_upd = 0; e_taken = 0; e_idx = 0;
      check_regs();
      chk("rst_flush", 32'(flush), 32'd0);
      chk("rst_redirect", redirect_pc, 32'd0);
      rst = 1'b0;
   endtask

   initial begin
      do_reset();

      // Three branches, first resolves correctly.
      cyc(1, 1, 4'd5, 32'h100, 32'h140, 0, 0, 0);
      cyc(1, 0, 4'd2, 32'h104, 32'h0,   0, 0, 0);
      cyc(1, 1, 4'd9, 32'h108, 32'h200, 0, 0, 0);
      cyc(0, 0, 0, 0, 0, 1, 1, 32'h140);
      chk("tp1_flush", 32'(obs_flush), 32'd0);
      chk("tp1_upd", 32'(pred_update), 32'd1);
      chk("tp1_idx", 32'(pred_update_idx), 32'd5);
      chk("tp1_total", br_total, 32'd1);

      // Predicted not-taken, actually taken: flush and clear.
      cyc(0, 0, 0, 0, 0, 1, 1, 32'h180);
      chk("tp2_flush", 32'(obs_flush), 32'd1);
      chk("tp2_redirect", obs_redirect, 32'h180);
      chk("tp2_idx", 32'(pred_update_idx), 32'd2);
      chk("tp2_mispred", br_mispred, 32'd1);
      cyc(0, 0, 0, 0, 0, 1, 1, 32'h108);
      chk("tp2_cleared", 32'(pred_update), 32'd0);

      // Right direction, wrong target.
      cyc(1, 1, 4'd9, 32'h108, 32'h200, 0, 0, 0);
      cyc(0, 0, 0, 0, 0, 1, 1, 32'h204);
      chk("tp3_flush", 32'(obs_flush), 32'd1);
      chk("tp3_redirect", obs_redirect, 32'h204);

      // Fall-through PC wraps.
      cyc(1, 1, 4'd3, 32'hFFFF_FFFC, 32'h10, 0, 0, 0);
      cyc(0, 0, 0, 0, 0, 1, 0, 32'h0);
      chk("tp4_flush", 32'(obs_flush), 32'd1);
      chk("tp4_redirect", obs_redirect, 32'h0);

      // Fill, overflow push, push+pop at count 3, mispredict with concurrent push.
      for (int i = 1; i <= 5; i++) cyc(1, 0, 4'(i), 32'h400 + 32'(4 * i), 32'h0, 0, 0, 0);
      chk("tp5_full", 32'(id_full), 32'd1);
      cyc(0, 0, 0, 0, 0, 1, 0, 32'h0);
      cyc(1, 0, 4'd6, 32'h500, 32'h0, 1, 0, 32'h0);
      chk("tp5_count3", 32'(id_full), 32'd0);
      cyc(1, 0, 4'd7, 32'h504, 32'h0, 0, 0, 0);
      chk("tp5_full_again", 32'(id_full), 32'd1);
      cyc(1, 0, 4'd8, 32'h508, 32'h0, 1, 1, 32'h600);
      chk("tp5_mis_idx", 32'(pred_update_idx), 32'd3);
      chk("tp5_empty", 32'(id_full), 32'd0);

      // Resolve on empty.
      cyc(0, 0, 0, 0, 0, 1, 1, 32'h50);
      chk("tp6_flush", 32'(obs_flush), 32'd0);
      chk("tp6_noupd", 32'(pred_update), 32'd0);

      // Reset with entries in flight and an update pending.
      cyc(1, 1, 4'd10, 32'h700, 32'h740, 0, 0, 0);
      cyc(1, 0, 4'd11, 32'h704, 32'h0,   0, 0, 0);
      cyc(1, 0, 4'd12, 32'h708, 32'h0,   1, 1, 32'h740);
      do_reset();
      chk("tp7_total", br_total, 32'd0);
      cyc(0, 0, 0, 0, 0, 1, 0, 32'h0);
      chk("tp7_empty", 32'(pred_update), 32'd0);

      // Randomized traffic against the model.
      for (int n = 0; n < 600; n++) begin
         bit        p, r, t;
         bit [31:0] tg;
         ent_t      h;
         if ($urandom_range(0, 99) == 0) begin
            do_reset();
            continue;
         end
         p = ($urandom_range(0, 1) == 1);
         r = ($urandom_range(0, 2) != 0);
         h = (q.size() != 0) ? q[0] : '0;
         t = ($urandom_range(0, 3) != 0) ? h.pred : ~h.pred;
         tg = ($urandom_range(0, 3) != 0) ? h.addr : $urandom;
         cyc(p, 1'($urandom), 4'($urandom), $urandom, $urandom, r, t, tg);
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
